// File: rtl/commit_trace_buffer.sv
// Post-commit debug trace buffer: circular capture of the ROB commit stream with a
// PC-match trigger, post-trigger window, freeze and oldest-first readout.
module commit_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int TRIG_POST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_instr,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_rd_wdata,
    input  logic                     flush_in_prog,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic                     clear,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic [31:0]              rd_wdata,
    output logic [4:0]               rd_rd,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              commit_total,
    output logic [15:0]              dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 101;

    typedef enum logic [1:0] {
        S_CAPTURE = 2'b00,
        S_POST    = 2'b01,
        S_FROZEN  = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_post_cnt;
    logic [31:0]     r_commit_total;
    logic [15:0]     r_dropped;
    logic            r_rd_ack;
    logic [31:0]     r_rd_pc;
    logic [31:0]     r_rd_instr;
    logic [31:0]     r_rd_wdata;
    logic [4:0]      r_rd_rd;

    logic            w_qual;
    logic            w_trig;
    logic            w_full;
    logic            w_capture_en;
    logic            w_frozen;
    logic            w_write;
    logic            w_rd;
    logic [EW-1:0]   w_rd_entry;

    assign w_qual     = commit_valid && !flush_in_prog;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_trig     = w_qual && (r_state == S_CAPTURE) && trig_en && (commit_pc == trig_pc);
    assign w_write    = w_qual && w_capture_en && !clear;
    assign w_rd       = rd_req && w_frozen && (r_count != '0) && !clear;
    assign w_rd_entry = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: if (w_trig) w_next_state = (TRIG_POST == 0) ? S_FROZEN : S_POST;
                S_POST:    if (w_qual && r_post_cnt == 8'd1) w_next_state = S_FROZEN;
                S_FROZEN:  w_next_state = S_FROZEN;
                default:   w_next_state = S_CAPTURE;
            endcase
        end
    end

    always_comb begin
        w_capture_en = 1'b0;
        w_frozen     = 1'b0;
        case (r_state)
            S_CAPTURE, S_POST: w_capture_en = 1'b1;
            S_FROZEN:          w_frozen     = 1'b1;
            default:           w_capture_en = 1'b0;
        endcase
    end

    // Trace storage is deliberately left out of reset so a post-mortem dump survives.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {commit_pc, commit_instr, commit_rd, commit_rd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_post_cnt     <= '0;
            r_commit_total <= '0;
            r_dropped      <= '0;
            r_rd_ack       <= 1'b0;
            r_rd_pc        <= '0;
            r_rd_instr     <= '0;
            r_rd_wdata     <= '0;
            r_rd_rd        <= '0;
        end else if (clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_post_cnt     <= '0;
            r_commit_total <= '0;
            r_dropped      <= '0;
            r_rd_ack       <= 1'b0;
        end else begin
            r_rd_ack <= w_rd;
            if (w_qual) begin
                r_commit_total <= r_commit_total + 32'd1;
            end
            if (w_qual && w_frozen && r_dropped != 16'hFFFF) begin
                r_dropped <= r_dropped + 16'd1;
            end
            if (w_trig) begin
                r_post_cnt <= 8'(TRIG_POST);
            end else if (r_state == S_POST && w_qual) begin
                r_post_cnt <= r_post_cnt - 8'd1;
            end
            // Writes and reads are mutually exclusive: writes never happen while frozen.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_full) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
            if (w_rd) begin
                r_rd_pc    <= w_rd_entry[100:69];
                r_rd_instr <= w_rd_entry[68:37];
                r_rd_rd    <= w_rd_entry[36:32];
                r_rd_wdata <= w_rd_entry[31:0];
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_count    <= r_count - CW'(1);
            end
        end
    end

    assign state        = r_state;
    assign count        = r_count;
    assign commit_total = r_commit_total;
    assign dropped      = r_dropped;
    assign rd_ack       = r_rd_ack;
    assign rd_pc        = r_rd_pc;
    assign rd_instr     = r_rd_instr;
    assign rd_wdata     = r_rd_wdata;
    assign rd_rd        = r_rd_rd;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: table vectors for capture/flush/clear plus
// hand sequences for trigger windows, readout, TRIG_POST=0 and reset during POST.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_instr = '0;
    logic [4:0]  commit_rd = '0;
    logic [31:0] commit_rd_wdata = '0;
    logic        flush_in_prog = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        clear = 1'b0;
    logic        rd_req = 1'b0;

    logic        a_ack, z_ack;
    logic [31:0] a_pc, a_instr, a_wdata, z_pc, z_instr, z_wdata;
    logic [4:0]  a_rd, z_rd;
    logic [1:0]  a_state, z_state;
    logic [4:0]  a_count, z_count;
    logic [31:0] a_total, z_total;
    logic [15:0] a_drop, z_drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .TRIG_POST(8)) u_dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_rd_wdata(commit_rd_wdata),
        .flush_in_prog(flush_in_prog), .trig_en(trig_en), .trig_pc(trig_pc), .clear(clear),
        .rd_req(rd_req), .rd_ack(a_ack), .rd_pc(a_pc), .rd_instr(a_instr), .rd_wdata(a_wdata),
        .rd_rd(a_rd), .state(a_state), .count(a_count), .commit_total(a_total), .dropped(a_drop)
    );

    commit_trace_buffer #(.DEPTH(16), .TRIG_POST(0)) u_dut0 (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_rd_wdata(commit_rd_wdata),
        .flush_in_prog(flush_in_prog), .trig_en(trig_en), .trig_pc(trig_pc), .clear(clear),
        .rd_req(rd_req), .rd_ack(z_ack), .rd_pc(z_pc), .rd_instr(z_instr), .rd_wdata(z_wdata),
        .rd_rd(z_rd), .state(z_state), .count(z_count), .commit_total(z_total), .dropped(z_drop)
    );

    typedef struct {
        logic        cv;
        logic        fl;
        logic        te;
        logic        clr;
        logic        rq;
        logic [31:0] pc;
        int          e_cnt;
        int          e_st;
        int          e_tot;
        int          e_drop;
        int          e_ack;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic v, input logic [31:0] pc, input logic [4:0] rd);
        commit_valid    = v;
        commit_pc       = pc;
        commit_instr    = ~pc;
        commit_rd       = rd;
        commit_rd_wdata = pc ^ 32'hA5A5_0000;
    endtask

    initial begin
        // Capture / flush / clear vectors; trig_pc=0x80 only matters on the clear row.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60, 1, 0, 1, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h64, 2, 0, 2, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h68, 3, 0, 3, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6C, 4, 0, 4, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h70, 5, 0, 5, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  5, 0, 5, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h74, 5, 0, 5, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  5, 0, 5, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 0, 0, 0, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h84, 1, 0, 1, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  0, 0, 0, 0, 0};

        rst = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_total", a_total, 32'd0);
        chk("rst_drop", 32'(a_drop), 32'd0);
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_rdpc", a_pc, 32'd0);
        rst = 1'b1;

        trig_pc = 32'h80;
        for (int i = 0; i < 11; i++) begin
            set_commit(tbl[i].cv, tbl[i].pc, 5'd1);
            flush_in_prog = tbl[i].fl;
            trig_en       = tbl[i].te;
            clear         = tbl[i].clr;
            rd_req        = tbl[i].rq;
            tick();
            chk($sformatf("v%0d_count", i), 32'(a_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_state", i), 32'(a_state), 32'(tbl[i].e_st));
            chk($sformatf("v%0d_total", i), a_total, 32'(tbl[i].e_tot));
            chk($sformatf("v%0d_drop", i), 32'(a_drop), 32'(tbl[i].e_drop));
            chk($sformatf("v%0d_ack", i), 32'(a_ack), 32'(tbl[i].e_ack));
            chk($sformatf("v%0d_z_state", i), 32'(z_state), 32'(tbl[i].e_st));
        end
        set_commit(1'b0, 32'h0, 5'd0);
        flush_in_prog = 1'b0;
        trig_en = 1'b0;
        clear = 1'b0;
        rd_req = 1'b0;

        // Trigger at i=16, 8 post commits, then 6 dropped commits.
        trig_pc = 32'h1040;
        trig_en = 1'b1;
        for (int i = 0; i < 31; i++) begin
            set_commit(1'b1, 32'h1000 + 32'(4 * i), 5'(i));
            tick();
            chk($sformatf("trig_state_i%0d", i), 32'(a_state),
                (i < 16) ? 32'd0 : (i < 24) ? 32'd1 : 32'd2);
        end
        set_commit(1'b0, 32'h0, 5'd0);
        trig_en = 1'b0;
        chk("trig_drop", 32'(a_drop), 32'd6);
        chk("trig_total", a_total, 32'd31);
        chk("trig_count", 32'(a_count), 32'd16);
        chk("trig_ack_idle", 32'(a_ack), 32'd0);

        rd_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] epc;
            epc = 32'h1024 + 32'(4 * k);
            tick();
            chk($sformatf("rd%0d_ack", k), 32'(a_ack), 32'd1);
            chk($sformatf("rd%0d_pc", k), a_pc, epc);
            chk($sformatf("rd%0d_instr", k), a_instr, ~epc);
            chk($sformatf("rd%0d_wdata", k), a_wdata, epc ^ 32'hA5A5_0000);
            chk($sformatf("rd%0d_rd", k), 32'(a_rd), 32'(9 + k));
            chk($sformatf("rd%0d_count", k), 32'(a_count), 32'(15 - k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("empty%0d_ack", k), 32'(a_ack), 32'd0);
            chk($sformatf("empty%0d_count", k), 32'(a_count), 32'd0);
            chk($sformatf("empty%0d_state", k), 32'(a_state), 32'd2);
            chk($sformatf("empty%0d_hold", k), a_pc, 32'h1060);
        end
        rd_req = 1'b0;

        // TRIG_POST=0 instance freezes right after the trigger commit.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_state", 32'(a_state), 32'd0);
        chk("clr_drop", 32'(a_drop), 32'd0);
        trig_pc = 32'h2008;
        trig_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_commit(1'b1, 32'h2000 + 32'(4 * i), 5'(i + 3));
            tick();
            chk($sformatf("tp0_z_state%0d", i), 32'(z_state), (i == 2) ? 32'd2 : 32'd0);
            chk($sformatf("tp0_a_state%0d", i), 32'(a_state), (i == 2) ? 32'd1 : 32'd0);
        end
        set_commit(1'b0, 32'h0, 5'd0);
        trig_en = 1'b0;
        chk("tp0_z_count", 32'(z_count), 32'd3);
        rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("tp0_rd%0d_ack", k), 32'(z_ack), 32'd1);
            chk($sformatf("tp0_rd%0d_pc", k), z_pc, 32'h2000 + 32'(4 * k));
            chk($sformatf("tp0_post_ack%0d", k), 32'(a_ack), 32'd0);
        end
        rd_req = 1'b0;
        chk("tp0_z_count_end", 32'(z_count), 32'd0);

        // Reset in the middle of the POST window.
        chk("prerst_state", 32'(a_state), 32'd1);
        rst = 1'b0;
        set_commit(1'b1, 32'h3000, 5'd7);
        tick();
        chk("mrst_state", 32'(a_state), 32'd0);
        chk("mrst_count", 32'(a_count), 32'd0);
        chk("mrst_total", a_total, 32'd0);
        chk("mrst_drop", 32'(a_drop), 32'd0);
        chk("mrst_ack", 32'(a_ack), 32'd0);
        chk("mrst_rdpc", a_pc, 32'd0);
        chk("mrst_z_rdpc", z_pc, 32'd0);
        chk("mrst_z_state", 32'(z_state), 32'd0);
        rst = 1'b1;
        set_commit(1'b0, 32'h0, 5'd0);
        tick();
        chk("post_rst_count", 32'(a_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
